// File: rtl/leitor_de_botoes.sv
// Button reader: per-channel synchroniser and debouncer, rising-edge press
// detection, priority encoder and one-deep valid/ack code register.
module leitor_de_botoes #(
  parameter  int N_BOTOES        = 10,
  parameter  int DEBOUNCE_CICLOS = 4,
  parameter  int LARGURA_SAIDA   = 12,
  localparam int W_COD           = $clog2(N_BOTOES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BOTOES-1:0]      botoes,
  output logic [LARGURA_SAIDA-1:0] saida_de_dados,
  output logic [W_COD-1:0]         codigo,
  output logic                     codigo_valido,
  input  logic                     codigo_ack,
  output logic                     evento_perdido
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

  logic [N_BOTOES-1:0] s1, s2, est, est_ant, novo;
  logic [CW-1:0]       cnt [N_BOTOES];
  logic [W_COD-1:0]    idx;
  logic                achou, multiplo, ack_eff, aceita, descarta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      est_ant <= '0;
    end else begin
      s1      <= botoes;
      s2      <= s1;
      est_ant <= est;
    end
  end

  // Any return of s2 to est before the threshold restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est <= '0;
      for (int unsigned i = 0; i < N_BOTOES; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BOTOES; i++) begin
        if (s2[i] == est[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CICLOS - 1)) begin
          est[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    saida_de_dados                = '0;
    saida_de_dados[N_BOTOES-1:0] = est;
  end

  assign novo     = est & ~est_ant;
  assign multiplo = |(novo & (novo - N_BOTOES'(1)));

  // Lowest index wins; any other simultaneous press is dropped.
  always_comb begin
    idx   = '0;
    achou = 1'b0;
    for (int unsigned i = 0; i < N_BOTOES; i++) begin
      if (novo[i] && !achou) begin
        idx   = W_COD'(i);
        achou = 1'b1;
      end
    end
  end

  assign ack_eff  = codigo_valido & codigo_ack;
  assign aceita   = achou & (~codigo_valido | codigo_ack);
  assign descarta = multiplo | (achou & codigo_valido & ~codigo_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codigo         <= '0;
      codigo_valido  <= 1'b0;
      evento_perdido <= 1'b0;
    end else begin
      if (aceita) begin
        codigo        <= idx;
        codigo_valido <= 1'b1;
      end else if (ack_eff) begin
        codigo_valido <= 1'b0;
      end
      if (descarta)     evento_perdido <= 1'b1;
      else if (ack_eff) evento_perdido <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leitor_de_botoes.sv
// Self-checking bench for leitor_de_botoes: fixed-latency checks plus a
// scoreboard queue of expected press codes.
module tb_leitor_de_botoes;

  localparam int N = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  botoes;
  logic [11:0]   saida_de_dados;
  logic [3:0]    codigo;
  logic          codigo_valido;
  logic          codigo_ack;
  logic          evento_perdido;

  int total = 0;
  int bad   = 0;
  int exp_q [$];

  leitor_de_botoes #(
    .N_BOTOES(10),
    .DEBOUNCE_CICLOS(4),
    .LARGURA_SAIDA(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .botoes(botoes),
    .saida_de_dados(saida_de_dados),
    .codigo(codigo),
    .codigo_valido(codigo_valido),
    .codigo_ack(codigo_ack),
    .evento_perdido(evento_perdido)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(codigo), 32'(e));
    end
  endtask

  task automatic ack_pulse();
    codigo_ack = 1'b1;
    tick(1);
    codigo_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; botoes = '0; codigo_ack = 1'b0;
    tick(3);
    check("rst_outs", {saida_de_dados, codigo, codigo_valido, evento_perdido}, 32'd0);
    rst = 1'b0;

    // idle: all outputs stay 0
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("idle", {saida_de_dados, codigo, codigo_valido, evento_perdido}, 32'd0);
    end

    // single press of button 3
    botoes = 10'h008; exp_q.push_back(3);
    tick(5);
    check("b3_saida_e5", saida_de_dados, 32'h000);
    tick(1);
    check("b3_saida_e6", saida_de_dados, 32'h008);
    check("b3_valid_e6", codigo_valido, 1'b0);
    tick(1);
    check("b3_valid_e7", codigo_valido, 1'b1);
    pop_check("b3_code");
    tick(4);
    check("b3_hold_valid", codigo_valido, 1'b1);
    ack_pulse();
    check("b3_ack_clear", codigo_valido, 1'b0);
    check("b3_code_kept", codigo, 4'd3);
    botoes = '0;
    tick(5);
    check("b3_rel_e5", saida_de_dados, 32'h008);
    tick(1);
    check("b3_rel_e6", saida_de_dados, 32'h000);
    tick(4);
    check("b3_rel_noevt", codigo_valido, 1'b0);

    // button 5 bouncing: 2-cycle pulses never pass
    for (int c = 0; c < 12; c++) begin
      botoes = ((c / 2) % 2 == 0) ? 10'h020 : 10'h000;
      tick(1);
      check("b5_bounce", saida_de_dados, 32'h000);
    end
    botoes = 10'h020; exp_q.push_back(5);
    tick(5);
    check("b5_e5", saida_de_dados, 32'h000);
    tick(1);
    check("b5_e6", saida_de_dados, 32'h020);
    tick(1);
    check("b5_valid", codigo_valido, 1'b1);
    pop_check("b5_code");
    ack_pulse();
    botoes = '0;
    tick(10);
    check("b5_one_evt", {codigo_valido, evento_perdido}, 32'd0);

    // press 1, no ack, then press 7 -> dropped
    botoes = 10'h002; exp_q.push_back(1);
    tick(7);
    check("p1_valid", codigo_valido, 1'b1);
    botoes = 10'h082;
    tick(7);
    check("p7_drop_flag", evento_perdido, 1'b1);
    pop_check("p1_code_kept");
    ack_pulse();
    check("p1_ack_valid", codigo_valido, 1'b0);
    check("p1_ack_perdido", evento_perdido, 1'b0);
    botoes = '0;
    tick(8);

    // buttons 2 and 9 simultaneously
    botoes = 10'h204; exp_q.push_back(2);
    tick(6);
    check("b29_saida", saida_de_dados, 32'h204);
    tick(1);
    check("b29_valid", codigo_valido, 1'b1);
    pop_check("b29_code");
    check("b29_perdido", evento_perdido, 1'b1);
    ack_pulse();
    check("b29_ack_perdido", evento_perdido, 1'b0);
    botoes = '0;
    tick(8);

    // ack on the same edge a new press (button 4) is accepted
    botoes = 10'h001; exp_q.push_back(0);
    tick(7);
    pop_check("b0_code");
    botoes = 10'h011; exp_q.push_back(4);
    tick(6);
    codigo_ack = 1'b1;
    tick(1);
    codigo_ack = 1'b0;
    check("b4_valid_held", codigo_valido, 1'b1);
    pop_check("b4_code");
    check("b4_perdido", evento_perdido, 1'b0);
    ack_pulse();
    check("b4_ack_clear", codigo_valido, 1'b0);
    botoes = '0;
    tick(8);

    // reset mid-debounce with a code pending
    botoes = 10'h100; exp_q.push_back(8);
    tick(7);
    pop_check("b8_code");
    botoes = '0;
    tick(8);
    botoes = 10'h001;
    tick(4);
    check("pre_rst_valid", codigo_valido, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async", {saida_de_dados, codigo, codigo_valido, evento_perdido}, 32'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b0; exp_q.push_back(0);
    tick(6);
    check("post_rst_saida", saida_de_dados, 32'h001);
    check("post_rst_e6", codigo_valido, 1'b0);
    tick(1);
    check("post_rst_e7", codigo_valido, 1'b1);
    pop_check("post_rst_code");
    check("post_rst_perdido", evento_perdido, 1'b0);
    ack_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
